// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 draw controller.
package chip8_pkg;

  localparam int unsigned FB_W             = 64;
  localparam int unsigned FB_H             = 32;
  localparam int unsigned FB_BYTES_PER_ROW = 8;
  localparam int unsigned MEM_AW_DEF       = 12;
  localparam int unsigned FB_AW_DEF        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FETCH,
    ST_RDL,
    ST_RDR,
    ST_WRL,
    ST_WRR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/chip8_sprite_split.sv
// Splits one sprite byte across the two framebuffer bytes it overlaps.
module chip8_sprite_split
  import chip8_pkg::*;
(
  input  logic [7:0] spr_i,
  input  logic [2:0] sh_i,
  output logic [7:0] left_o,
  output logic [7:0] right_o
);

  logic [15:0] wide;

  // Shift the byte into a 16-bit window; the top half lands in the left byte.
  always_comb begin
    wide    = {spr_i, 8'h00} >> sh_i;
    left_o  = wide[15:8];
    right_o = wide[7:0];
  end

endmodule

// File: rtl/chip8_draw_ctrl.sv
// CHIP-8 DXYN / 00E0 sequencer: fetches sprite rows, XORs them into the
// framebuffer byte-wise and reports VF. Optional clip mode: CHIP8_CLIP_EN.
module chip8_draw_ctrl
  import chip8_pkg::*;
#(
  parameter int unsigned MEM_AW = MEM_AW_DEF,
  parameter int unsigned FB_AW  = FB_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [3:0]        cmd_n,
  input  logic [MEM_AW-1:0] cmd_i,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              fb_rd,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata,
  output logic              done,
  output logic              collision
);

  state_e            state_q;
  logic [5:0]        x0_q;
  logic [4:0]        y0_q;
  logic [3:0]        n_q;
  logic [3:0]        r_q;
  logic [MEM_AW-1:0] i_q;
  logic [7:0]        spr_q;
  logic              coll_q;

  logic              ready_q;
  logic              mem_rd_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic              fb_rd_q;
  logic              fb_we_q;
  logic [FB_AW-1:0]  fb_addr_q;
  logic [7:0]        fb_wdata_q;
  logic              done_q;
  logic              collision_q;

  logic [2:0]        sh_c;
  logic [2:0]        byte_l_c;
  logic [2:0]        byte_r_c;
  logic [4:0]        row_c;
  logic [3:0]        r_nxt_c;
  logic              last_row_c;
  logic [FB_AW-1:0]  addr_l_c;
  logic [FB_AW-1:0]  addr_r_c;
  logic [7:0]        mask_l_c;
  logic [7:0]        mask_r_c;
  logic              has_right_c;
  logic [3:0]        n_d;
  logic              unused_bits;

  // Row/byte geometry of the current sprite row.
  assign sh_c       = x0_q[2:0];
  assign byte_l_c   = x0_q[5:3];
  assign byte_r_c   = byte_l_c + 3'd1;
  assign row_c      = y0_q + 5'(r_q);
  assign r_nxt_c    = r_q + 4'd1;
  assign last_row_c = (r_nxt_c >= n_q);
  assign addr_l_c   = FB_AW'({row_c, byte_l_c});
  assign addr_r_c   = FB_AW'({row_c, byte_r_c});
  assign unused_bits = ^{cmd_x[7:6], cmd_y[7:5]};

`ifdef CHIP8_CLIP_EN
  logic [5:0] rows_avail_c;
  // Rows falling off the bottom are dropped up front; right byte dropped at column 7.
  assign rows_avail_c = 6'(FB_H) - {1'b0, cmd_y[4:0]};
  assign n_d          = ({2'b00, cmd_n} > rows_avail_c) ? 4'(rows_avail_c) : cmd_n;
  assign has_right_c  = (sh_c != 3'd0) && (byte_l_c != 3'd7);
`else
  // Wrap mode: every row is drawn and the right byte wraps within the row.
  assign n_d          = cmd_n;
  assign has_right_c  = (sh_c != 3'd0);
`endif

  chip8_sprite_split u_split (
    .spr_i   (spr_q),
    .sh_i    (sh_c),
    .left_o  (mask_l_c),
    .right_o (mask_r_c)
  );

  // Sequencer with registered strobes; outputs are set on entry to each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      n_q         <= '0;
      r_q         <= '0;
      i_q         <= '0;
      spr_q       <= '0;
      coll_q      <= 1'b0;
      ready_q     <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      fb_rd_q     <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      mem_rd_q    <= 1'b0;
      fb_rd_q     <= 1'b0;
      fb_we_q     <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            x0_q    <= cmd_x[5:0];
            y0_q    <= cmd_y[4:0];
            n_q     <= n_d;
            i_q     <= cmd_i;
            r_q     <= '0;
            coll_q  <= 1'b0;
            ready_q <= 1'b0;
            if (cmd_clear) begin
              state_q    <= ST_CLR;
              fb_we_q    <= 1'b1;
              fb_addr_q  <= '0;
              fb_wdata_q <= 8'h00;
            end else if (n_d == 4'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= cmd_i;
            end
          end
        end
        ST_CLR: begin
          if (&fb_addr_q) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            collision_q <= coll_q;
          end else begin
            fb_we_q   <= 1'b1;
            fb_addr_q <= fb_addr_q + FB_AW'(1);
          end
        end
        ST_FETCH: begin
          state_q   <= ST_RDL;
          fb_rd_q   <= 1'b1;
          fb_addr_q <= addr_l_c;
        end
        ST_RDL: begin
          state_q   <= ST_RDR;
          spr_q     <= mem_rdata;
          fb_rd_q   <= has_right_c;
          fb_addr_q <= has_right_c ? addr_r_c : addr_l_c;
        end
        ST_RDR: begin
          // Old left byte is on fb_rdata now.
          state_q    <= ST_WRL;
          fb_we_q    <= 1'b1;
          fb_addr_q  <= addr_l_c;
          fb_wdata_q <= fb_rdata ^ mask_l_c;
          coll_q     <= coll_q | (|(fb_rdata & mask_l_c));
        end
        ST_WRL: begin
          if (has_right_c) begin
            // Old right byte is on fb_rdata now.
            state_q    <= ST_WRR;
            fb_we_q    <= 1'b1;
            fb_addr_q  <= addr_r_c;
            fb_wdata_q <= fb_rdata ^ mask_r_c;
            coll_q     <= coll_q | (|(fb_rdata & mask_r_c));
          end else if (last_row_c) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            collision_q <= coll_q;
          end else begin
            state_q    <= ST_FETCH;
            r_q        <= r_nxt_c;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= i_q + MEM_AW'(r_nxt_c);
          end
        end
        ST_WRR: begin
          if (last_row_c) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            collision_q <= coll_q;
          end else begin
            state_q    <= ST_FETCH;
            r_q        <= r_nxt_c;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= i_q + MEM_AW'(r_nxt_c);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Ready is held low for the whole time reset is asserted.
  assign cmd_ready = ready_q & ~reset;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign fb_rd     = fb_rd_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign done      = done_q;
  assign collision = collision_q;

endmodule

// File: doc/chip8_draw_ctrl.md
# chip8_draw_ctrl

Sequencer for the CHIP-8 DXYN sprite-draw and 00E0 clear-screen operations. It accepts one command from the CPU core and fetches sprite rows from main memory. It then performs byte-wide read-modify-write XOR on the 64x32 framebuffer RAM and reports the VF collision flag. It sits between the CPU execute stage, main memory and the framebuffer, and is the only writer of the framebuffer.

## Interface
Parameters:
- MEM_AW, 12: main-memory address width.
- FB_AW, 8: framebuffer address width (256 bytes, 8 bytes per row).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle; a command is accepted when valid and ready are both high.
- cmd_clear  in  1  1 selects clear screen; 0 selects sprite draw.
- cmd_x  in  8  Vx; reduced mod 64.
- cmd_y  in  8  Vy; reduced mod 32.
- cmd_n  in  4  sprite height in rows.
- cmd_i  in  MEM_AW  sprite base address (I register).
- mem_rd  out  1  sprite byte read strobe.
- mem_addr  out  MEM_AW  sprite byte address.
- mem_rdata  in  8  sprite byte, valid one cycle after mem_rd.
- fb_rd  out  1  framebuffer read strobe.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  FB_AW  framebuffer address, {row[4:0], byte[2:0]}.
- fb_wdata  out  8  write data.
- fb_rdata  in  8  read data, valid one cycle after fb_rd.
- done  out  1  one-cycle completion pulse.
- collision  out  1  VF result; valid while done is high, 0 otherwise.

## Operation
- States: IDLE, CLR, FETCH, RDL, RDR, WRL, WRR, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch x0=cmd_x[5:0], y0=cmd_y[4:0], n, I and sh=x0[2:0]; clear the collision accumulator.
  - Go to CLR if cmd_clear=1, else to FETCH; if n=0, go directly to DONE.
- CLR: fb_we=1 and fb_wdata=0 for fb_addr 0..255, one address per cycle, then DONE.
- Per sprite row r:
  - FETCH: mem_rd=1, mem_addr=I+r (wraps mod 2^MEM_AW).
  - RDL: latch spr=mem_rdata; fb_rd=1 at the left byte, {(y0+r) mod 32, x0[5:3]}.
  - RDR: latch the old left byte; if sh≠0, fb_rd=1 at the right byte, byte index (x0[5:3]+1) mod 8.
  - WRL: if sh≠0, latch the old right byte. Write left = old ^ (spr>>sh). Accumulate collision |= |(old & (spr>>sh)).
  - WRR: entered only if sh≠0. Write right = old ^ (spr<<(8−sh)). Accumulate collision likewise.
  - After the row: go to FETCH for r+1 while r+1<n, else DONE.
- DONE: done=1 and collision = the accumulated value (0 for clear and for n=0); cmd_ready=0; next state IDLE.
- cmd_valid is ignored outside IDLE.
- Reset mid-operation: state returns to IDLE on the next edge and all strobes drop. Framebuffer bytes already written are not restored.

## Timing
- Reset values: cmd_ready=0 while reset is high, and all other outputs 0. cmd_ready=1 in the first cycle after reset deasserts.
- Let cycle 0 be the accept cycle:
  - Aligned draw (sh=0): 4 cycles per row; done in cycle 4n+1.
  - Unaligned draw: 5 cycles per row; done in cycle 5n+1.
  - n=0: done in cycle 1.
  - Clear: done in cycle 257.
- Earliest next accept: the cycle after done.
- At most one of fb_rd and fb_we is high in any cycle.

## Configuration
- CHIP8_CLIP_EN defined (clip mode):
  - Rows with y0+r≥32 are skipped at zero cycle cost.
  - When x0[5:3]=7, the right byte is neither read nor written; WRR is skipped.
  - Latencies shrink accordingly.
- CHIP8_CLIP_EN undefined (wrap mode): rows and the right byte wrap modulo 32 and modulo 8.

## Structure
- chip8_pkg holds the state enum, the constants FB_W=64, FB_H=32, FB_BYTES_PER_ROW=8 and the default address widths.
- One sub-module, chip8_sprite_split, is combinational. It takes spr and sh and returns the left and right masks.

## Test plan
- Reset mid-draw → cmd_ready=0 while reset is high; after release, cmd_ready=1, done=0, and no further fb_we.
- Clear: cmd_clear=1 → 256 writes of 0x00, addresses 0..255; done in cycle 257; collision=0.
- Aligned draw on a zero framebuffer: x=8, y=4, n=1, mem[I]=0xF0:
  - fb[0x21] becomes 0xF0 and done arrives in cycle 5 with collision=0.
  - Repeating the same draw gives fb[0x21]=0x00 and collision=1.
- Unaligned draw on a zero framebuffer: x=10, y=4, mem=0xFF → fb[0x21]=0x3F, fb[0x22]=0xC0, done in cycle 6.
- Edge draw: x=60, y=31, n=2, bytes 0xFF,0xFF:
  - Wrap mode: touches 0xFF/0xF8, 0xFF/0xF8 and 0x07/0x00 (left/right byte addresses of rows 31 and 0).
  - Clip mode: writes only fb[0xFF]=0x0F; done in cycle 5.
- n=0 → done in cycle 1, collision=0, no memory or framebuffer strobes.
